// File: rtl/alu_writeback.sv
// ALU result writeback buffer: a small circular FIFO between the ALU and the
// register-file write port, with compare flags, hazard lookup and occupancy.
module alu_writeback #(
  parameter int          DEPTH  = 2,       // 2 or 4 only (pointers wrap by width)
  parameter int          AW     = 3,
  parameter logic [2:0]  OP_SUB = 3'b001   // mcSUB encoding
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_dest,
  input  logic          in_wr_en,
  input  logic          rf_ready,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_addr,
  output logic [7:0]    rf_data,
  output logic          flag_eq,
  output logic          flag_lt,
  input  logic [AW-1:0] haz_addr,
  output logic          hazard,
  output logic [2:0]    count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [7:0]    data_mem [DEPTH];
  logic [2:0]    op_mem   [DEPTH];
  logic [AW-1:0] dest_mem [DEPTH];
  logic          wren_mem [DEPTH];

  logic [PW-1:0] head_reg, tail_reg;
  logic [2:0]    count_reg;
  logic          flag_eq_reg, flag_lt_reg;

  logic          not_empty;
  logic          push, pop;
  logic [DEPTH-1:0] entry_hit;

  assign not_empty = (count_reg != 3'd0);
  assign in_ready  = rst_n && (count_reg < 3'(DEPTH));
  assign push      = in_valid && in_ready;
  // A flags-only head never waits on the register-file port.
  assign pop       = not_empty && (!wren_mem[head_reg] || rf_ready);

  assign rf_wr_en = not_empty && wren_mem[head_reg] && rf_ready;
  assign rf_addr  = not_empty ? dest_mem[head_reg] : '0;
  assign rf_data  = not_empty ? data_mem[head_reg] : 8'd0;
  assign flag_eq  = flag_eq_reg;
  assign flag_lt  = flag_lt_reg;
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail_reg] <= in_data;
      op_mem[tail_reg]   <= in_op;
      dest_mem[tail_reg] <= in_dest;
      wren_mem[tail_reg] <= in_wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= 3'd0;
      flag_eq_reg <= 1'b0;
      flag_lt_reg <= 1'b0;
    end else begin
      if (push)
        tail_reg <= tail_reg + PW'(1);
      if (pop) begin
        head_reg <= head_reg + PW'(1);
        if (op_mem[head_reg] == OP_SUB) begin
          flag_eq_reg <= (data_mem[head_reg] == 8'd0);
          flag_lt_reg <= data_mem[head_reg][7];
        end
      end
      if (push && !pop)
        count_reg <= count_reg + 3'd1;
      else if (pop && !push)
        count_reg <= count_reg - 3'd1;
    end
  end

  // An entry is occupied when its distance from head is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
      logic [PW-1:0] offset;
      assign offset        = PW'(gi) - head_reg;
      assign entry_hit[gi] = (3'(offset) < count_reg) && wren_mem[gi]
                             && (dest_mem[gi] == haz_addr);
    end
  endgenerate

  assign hazard = (|entry_hit) || (in_valid && in_wr_en && (in_dest == haz_addr));

endmodule

// File: tb/tb_alu_writeback.sv
// Directed and randomized check of alu_writeback against a queue-based model.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int AW    = 3;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'd0;
  logic [2:0]    in_op = 3'd0;
  logic [AW-1:0] in_dest = '0;
  logic          in_wr_en = 1'b0;
  logic          rf_ready = 1'b0;
  logic          rf_wr_en;
  logic [AW-1:0] rf_addr;
  logic [7:0]    rf_data;
  logic          flag_eq, flag_lt;
  logic [AW-1:0] haz_addr = '0;
  logic          hazard;
  logic [2:0]    count;

  alu_writeback #(.DEPTH(DEPTH), .AW(AW), .OP_SUB(OP_SUB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_dest(in_dest), .in_wr_en(in_wr_en),
    .rf_ready(rf_ready), .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .flag_eq(flag_eq), .flag_lt(flag_lt), .haz_addr(haz_addr), .hazard(hazard),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    data;
    logic [2:0]    op;
    logic [AW-1:0] dest;
    logic          wren;
  } ent_t;

  ent_t q[$];
  logic m_eq = 1'b0;
  logic m_lt = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic [2:0] op,
                        input logic [AW-1:0] dest, input logic we);
    in_valid = v; in_data = d; in_op = op; in_dest = dest; in_wr_en = we;
  endtask

  // Compare every output against what the queue model says it should be now.
  task automatic check_all(input string tag);
    logic exp_haz;
    #1;
    exp_haz = in_valid && in_wr_en && (in_dest == haz_addr);
    foreach (q[i]) if (q[i].wren && q[i].dest == haz_addr) exp_haz = 1'b1;
    chk({tag, "/count"},    8'(count),    8'(q.size()));
    chk({tag, "/in_ready"}, 8'(in_ready), 8'(rst_n && q.size() < DEPTH));
    chk({tag, "/rf_wr_en"}, 8'(rf_wr_en), 8'(q.size() > 0 && q[0].wren && rf_ready));
    chk({tag, "/rf_addr"},  8'(rf_addr),  q.size() > 0 ? 8'(q[0].dest) : 8'd0);
    chk({tag, "/rf_data"},  rf_data,      q.size() > 0 ? q[0].data : 8'd0);
    chk({tag, "/flag_eq"},  8'(flag_eq),  8'(m_eq));
    chk({tag, "/flag_lt"},  8'(flag_lt),  8'(m_lt));
    chk({tag, "/hazard"},   8'(hazard),   8'(exp_haz));
  endtask

  // Advance one clock edge and update the model with what that edge should do.
  task automatic cycle();
    bit   do_pop, do_push;
    ent_t e;
    do_pop  = rst_n && q.size() > 0 && (!q[0].wren || rf_ready);
    do_push = rst_n && in_valid && q.size() < DEPTH;
    e = '{data: in_data, op: in_op, dest: in_dest, wren: in_wr_en};
    @(posedge clk);
    if (do_pop) begin
      if (q[0].op == OP_SUB) begin
        m_eq = (q[0].data == 8'd0);
        m_lt = q[0].data[7];
      end
      $display("retire data=%02h dest=%0d wren=%0b op=%0d", q[0].data, q[0].dest, q[0].wren, q[0].op);
      void'(q.pop_front());
    end
    if (do_push) begin
      q.push_back(e);
      $display("push   data=%02h dest=%0d wren=%0b op=%0d", e.data, e.dest, e.wren, e.op);
    end
    #1;
  endtask

  initial begin
    // Reset state
    check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("post_reset");

    // Single write with port free
    rf_ready = 1'b1;
    set_in(1, 8'h2A, OP_ADD, 3, 1);
    check_all("w1_push");
    cycle();
    set_in(0, 8'h00, OP_ADD, 0, 0);
    check_all("w1_head");
    chk("w1_wr", 8'(rf_wr_en), 8'd1);
    chk("w1_addr", 8'(rf_addr), 8'd3);
    chk("w1_data", rf_data, 8'h2A);
    cycle();
    check_all("w1_done");
    chk("w1_cnt0", 8'(count), 8'd0);

    // Fill while port busy, then drain in order
    rf_ready = 1'b0;
    set_in(1, 8'h11, OP_ADD, 1, 1); check_all("fill1"); cycle();
    set_in(1, 8'h22, OP_ADD, 2, 1); check_all("fill2"); cycle();
    set_in(1, 8'h33, OP_ADD, 3, 1); check_all("fill_full");
    chk("full_cnt", 8'(count), 8'd2);
    chk("full_rdy", 8'(in_ready), 8'd0);
    cycle();
    set_in(0, 8'h00, OP_ADD, 0, 0);
    rf_ready = 1'b1;
    check_all("drain1");
    chk("drain1_data", rf_data, 8'h11);
    cycle();
    check_all("drain2");
    chk("drain2_data", rf_data, 8'h22);
    cycle();
    check_all("drained");

    // Flags-only subtracts retire without RF writes
    rf_ready = 1'b0;
    set_in(1, 8'h00, OP_SUB, 4, 0); check_all("sub1"); cycle();
    set_in(1, 8'h80, OP_SUB, 4, 0); check_all("sub2");
    chk("sub_nowr", 8'(rf_wr_en), 8'd0);
    cycle();
    chk("sub1_eq", 8'(flag_eq), 8'd1);
    chk("sub1_lt", 8'(flag_lt), 8'd0);
    set_in(0, 8'h00, OP_ADD, 0, 0);
    check_all("sub_mid");
    cycle();
    check_all("sub_done");
    chk("sub2_eq", 8'(flag_eq), 8'd0);
    chk("sub2_lt", 8'(flag_lt), 8'd1);

    // Hazard lookup
    set_in(1, 8'h55, OP_ADD, 5, 1); cycle();
    set_in(0, 8'h00, OP_ADD, 0, 0);
    haz_addr = 5; check_all("haz_hit");   chk("haz5", 8'(hazard), 8'd1);
    haz_addr = 4; check_all("haz_miss");  chk("haz4", 8'(hazard), 8'd0);
    set_in(1, 8'h66, OP_ADD, 4, 1); check_all("haz_in"); chk("haz_in4", 8'(hazard), 8'd1);
    set_in(0, 8'h00, OP_ADD, 0, 0);
    haz_addr = 5; rf_ready = 1'b1;
    check_all("haz_retire");
    cycle();
    check_all("haz_clear"); chk("haz_after", 8'(hazard), 8'd0);

    // Steady push/retire across pointer wrap
    set_in(1, 8'hA0, OP_ADD, 1, 1); cycle();
    for (int i = 1; i <= 10; i++) begin
      set_in(1, 8'(8'hA0 + i), OP_ADD, 3'(i), 1);
      check_all("wrap");
      chk("wrap_cnt", 8'(count), 8'd1);
      chk("wrap_data", rf_data, 8'(8'hA0 + i - 1));
      cycle();
    end
    set_in(0, 8'h00, OP_ADD, 0, 0);
    cycle();
    check_all("wrap_done");

    // Mid-operation reset discards buffered writes
    set_in(1, 8'h80, OP_SUB, 0, 0); cycle();   // leaves flag_lt=1
    rf_ready = 1'b0;
    set_in(1, 8'h77, OP_ADD, 6, 1); cycle();
    set_in(1, 8'h78, OP_ADD, 7, 1); cycle();
    set_in(0, 8'h00, OP_ADD, 0, 0);
    check_all("pre_rst");
    chk("pre_rst_cnt", 8'(count), 8'd2);
    #2 rst_n = 1'b0;
    q.delete(); m_eq = 1'b0; m_lt = 1'b0;
    check_all("in_rst");
    chk("rst_cnt", 8'(count), 8'd0);
    chk("rst_wr", 8'(rf_wr_en), 8'd0);
    chk("rst_lt", 8'(flag_lt), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rf_ready = 1'b1;
    check_all("rst_rel");
    chk("rst_rdy", 8'(in_ready), 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_nowr", 8'(rf_wr_en), 8'd0);
      cycle();
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 1) == 1, 8'($urandom), ($urandom_range(0, 1) == 1) ? OP_SUB : 3'($urandom),
             AW'($urandom), $urandom_range(0, 3) != 0);
      rf_ready = $urandom_range(0, 2) != 0;
      haz_addr = AW'($urandom);
      check_all("rand");
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered ALU results; legal values 2 and 4 only.
REQ-002 Parameter AW, default 3, register-file address width.
REQ-003 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset: asserted when 0, takes effect immediately, released synchronously to CLK by the integrator.
REQ-005 InValid  in  1  ALU result presented this cycle.
REQ-006 InReady  out  1  block can accept a result this cycle.
REQ-007 InData  in  8  ALU Out value.
REQ-008 InOP  in  3  ALU opcode (definitions package encoding) that produced InData.
REQ-009 InDest  in  AW  destination register index.
REQ-010 InWrEn  in  1  result writes the register file (0 = flags-only, e.g. compare).
REQ-011 RfReady  in  1  register-file write port free this cycle.
REQ-012 RfWrEn  out  1  register-file write strobe.
REQ-013 RfAddr  out  AW  write address.
REQ-014 RfData  out  8  write data.
REQ-015 FlagEq  out  1  last retired mcSUB result was zero.
REQ-016 FlagLt  out  1  last retired mcSUB result was negative (bit 7 set).
REQ-017 HazAddr  in  AW  source register queried by decode.
REQ-018 Hazard  out  1  a pending write targets HazAddr.
REQ-019 Count  out  3  number of occupied entries, 0..DEPTH.

Function
REQ-020 Storage SHALL be a DEPTH-entry circular FIFO of {InData, InOP, InDest, InWrEn} with head/tail pointers wrapping modulo DEPTH.
REQ-021 InReady SHALL equal (Count < DEPTH), combinational from registered state only, independent of RfReady.
REQ-022 A push SHALL occur on a rising edge where InValid && InReady; InValid while InReady=0 SHALL be ignored with no state change.
REQ-023 The head entry SHALL retire on a rising edge where Count>0 && (head.WrEn==0 || RfReady).
REQ-024 RfWrEn SHALL be (Count>0 && head.WrEn && RfReady); RfAddr/RfData SHALL show head Dest/Data whenever Count>0, else 0.
REQ-025 Latency: a result pushed at edge N SHALL be visible at the head no earlier than the cycle after edge N; there is no same-cycle bypass to RfWrEn.
REQ-026 Simultaneous push and retire SHALL leave Count unchanged; at Count=DEPTH no push occurs, so a retire only decrements.
REQ-027 Retirement SHALL be in push order; no entry is dropped or duplicated across pointer wrap.
REQ-028 On retire of a head with OP==mcSUB, FlagEq SHALL become (Data==0) and FlagLt SHALL become Data[7] at that edge; other opcodes SHALL leave both flags unchanged.
REQ-029 Hazard SHALL be combinational: 1 if any occupied entry has WrEn=1 and Dest==HazAddr, or if InValid && InWrEn && InDest==HazAddr; else 0.
REQ-030 A flags-only entry (WrEn=0) SHALL retire in one cycle regardless of RfReady and SHALL never assert RfWrEn.

Reset
REQ-031 While Reset=0: Count=0, pointers=0, FlagEq=0, FlagLt=0, InReady=0, RfWrEn=0, RfAddr=0, RfData=0, Hazard driven only by the InValid term.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries with no register-file write issued; InReady SHALL return to 1 in the first cycle after release.

Verification
REQ-033 Push {Data=0x2A, Dest=3, WrEn=1, OP=mcADD} with RfReady=1 -> next cycle RfWrEn=1, RfAddr=3, RfData=0x2A; following cycle Count=0, flags unchanged.
REQ-034 RfReady=0, push 0x11 (Dest 1) and 0x22 (Dest 2) on consecutive cycles -> Count=2, InReady=0, third push ignored; raise RfReady -> writes 0x11 then 0x22 on consecutive cycles.
REQ-035 Push mcSUB Data=0x00 WrEn=0, then mcSUB Data=0x80 WrEn=0 -> after first retire FlagEq=1, FlagLt=0; after second FlagEq=0, FlagLt=1; RfWrEn never asserted.
REQ-036 Entry Dest=5 held (RfReady=0), HazAddr=5 -> Hazard=1; HazAddr=4 -> Hazard=0; after the write retires with HazAddr=5 and InValid=0 -> Hazard=0.
REQ-037 Count=1 with RfReady=1 and a push in the same cycle, repeated 10 cycles over pointer wrap -> Count stays 1, data retired in exact push order.
REQ-038 Count=2 with RfReady=0, drive Reset=0 for one cycle -> Count=0, RfWrEn=0 immediately, flags 0, no write of buffered data after release.
